// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the BCD up-counter chain.
// Optional feature macro (used by bcd_up_counter_chain): BCD_COUNTER_STOP_AT_MAX_EN.
package bcd_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

    // A nibble is a legal BCD digit when it is 0..9.
    function automatic logic bcd_valid(input logic [BCD_DIGIT_W-1:0] nibble);
        return (nibble <= BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_up.sv
// One BCD digit of the up-counter chain: clear, preset, wrap-to-zero or
// increment by one with 9 -> 0 rollover. all_nine feeds the ripple enable
// of the next digit up.
module bcd_digit_up
    import bcd_counter_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   inc_in,
    input  logic                   clear,
    input  logic                   wrap_to_zero,
    input  logic                   load_en,
    input  logic [BCD_DIGIT_W-1:0] load_digit,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   all_nine
);

    logic [BCD_DIGIT_W-1:0] digit_q;
    logic [BCD_DIGIT_W-1:0] digit_d;

    // Next digit value: clear wins, then preset, then wrap, then increment.
    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = '0;
        end else if (load_en) begin
            digit_d = load_digit;
        end else if (wrap_to_zero) begin
            digit_d = '0;
        end else if (inc_in) begin
            digit_d = (digit_q >= BCD_DIGIT_MAX) ? '0 : digit_q + 4'd1;
        end
    end

    // Digit register with asynchronous clear to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit    = digit_q;
    assign all_nine = (digit_q == BCD_DIGIT_MAX);

endmodule

// File: rtl/bcd_up_counter_chain.sv
// Multi-digit BCD up-counter with run/pause/clear/load control and a
// one-cycle carry_out on wrap from MAX_VALUE to zero.
// Optional feature macro: BCD_COUNTER_STOP_AT_MAX_EN (stop in DONE at
// MAX_VALUE instead of wrapping; carry_out is then never raised).
module bcd_up_counter_chain
    import bcd_counter_pkg::*;
#(
    parameter int                  DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] MAX_VALUE = 8'h59
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry_out,
    output logic                  running,
    output logic                  load_err
);

    localparam int W = BCD_DIGIT_W * DIGITS;

    state_e        state_q;
    state_e        state_d;
    logic          carry_q;
    logic          carry_d;
    logic          load_err_q;
    logic          load_err_d;

    logic [W-1:0]      bcd_w;
    logic [DIGITS-1:0] all_nine;
    logic [DIGITS-1:0] ripple;
    logic [DIGITS-1:0] digit_inc;
    logic              inc_en;
    logic              clear_en;
    logic              load_en;
    logic              wrap;
    logic              at_max;
    logic              load_ok;

    // A preset is legal when every nibble is a BCD digit and it does not
    // exceed the wrap limit; for valid BCD the binary compare is MSD-first.
    always_comb begin
        load_ok = (load_value <= MAX_VALUE);
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_value[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    assign at_max = (bcd_w == MAX_VALUE);

    // Digit i may step only when every lower digit currently shows 9.
    always_comb begin
        logic acc;
        acc    = 1'b1;
        ripple = '0;
        for (int i = 0; i < DIGITS; i++) begin
            ripple[i] = acc;
            acc       = acc & all_nine[i];
        end
    end

`ifdef BCD_COUNTER_STOP_AT_MAX_EN
    logic [W-1:0] bcd_plus;
    logic         next_is_max;

    // Value one increment ahead, used to land in DONE on the same tick that reaches MAX_VALUE.
    always_comb begin
        bcd_plus = bcd_w;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple[i]) begin
                bcd_plus[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    all_nine[i] ? '0 : bcd_w[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
            end
        end
    end

    assign next_is_max = (bcd_plus == MAX_VALUE);
`endif

    // Control decode and next state; priority clear > load > stop > start > tick.
    always_comb begin
        state_d    = state_q;
        inc_en     = 1'b0;
        clear_en   = 1'b0;
        load_en    = 1'b0;
        load_err_d = 1'b0;
        carry_d    = 1'b0;
        if (clear) begin
            clear_en = 1'b1;
            state_d  = IDLE;
        end else if (load && (state_q != RUN)) begin
            if (load_ok) begin
                load_en = 1'b1;
                if (state_q == DONE) begin
                    state_d = PAUSE;
                end
            end else begin
                load_err_d = 1'b1;
            end
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (start) begin
            if ((state_q == IDLE) || (state_q == PAUSE)) begin
                state_d = RUN;
            end
        end else if (tick && (state_q == RUN)) begin
`ifdef BCD_COUNTER_STOP_AT_MAX_EN
            if (at_max) begin
                state_d = DONE;
            end else begin
                inc_en = 1'b1;
                if (next_is_max) begin
                    state_d = DONE;
                end
            end
`else
            inc_en  = 1'b1;
            carry_d = at_max;
`endif
        end
    end

    // State and registered pulse outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign wrap = inc_en & at_max;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign digit_inc[g] = inc_en & ~at_max & ripple[g];

        bcd_digit_up u_digit (
            .clock        (clock),
            .reset_n      (reset_n),
            .inc_in       (digit_inc[g]),
            .clear        (clear_en),
            .wrap_to_zero (wrap),
            .load_en      (load_en),
            .load_digit   (load_value[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit        (bcd_w[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .all_nine     (all_nine[g])
        );
    end

    assign bcd       = bcd_w;
    assign carry_out = carry_q;
    assign running   = (state_q == RUN);
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_up_counter_chain.sv
// Bench for bcd_up_counter_chain (DIGITS=2, MAX_VALUE=8'h59).
// A decimal reference model predicts each cycle's outputs.
module tb_bcd_up_counter_chain;

    localparam int MAX_INT  = 59;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSE  = 2;
    localparam int S_DONE   = 3;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       tick       = 1'b0;
    logic       start      = 1'b0;
    logic       stop       = 1'b0;
    logic       clear      = 1'b0;
    logic       load       = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] bcd;
    logic       carry_out;
    logic       running;
    logic       load_err;

    int errors = 0;
    int checks = 0;

    int mdl_val   = 0;
    int mdl_state = S_IDLE;

    typedef struct {
        string      tag;
        logic [7:0] bcd;
        logic       carry;
        logic       running;
        logic       load_err;
    } exp_t;

    exp_t sb[$];

    bcd_up_counter_chain #(
        .DIGITS    (2),
        .MAX_VALUE (8'h59)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .bcd        (bcd),
        .carry_out  (carry_out),
        .running    (running),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic preset_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (from_bcd(b) <= MAX_INT);
    endfunction

    task automatic compare(input string tag, input string field,
                           input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
        end
    endtask

    task automatic push_expect(input string tag, input logic carry, input logic lerr);
        exp_t e;
        e.tag      = tag;
        e.bcd      = to_bcd(mdl_val);
        e.carry    = carry;
        e.running  = (mdl_state == S_RUN);
        e.load_err = lerr;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            compare(e.tag, "bcd",      bcd,                 e.bcd);
            compare(e.tag, "carry",    {7'd0, carry_out},   {7'd0, e.carry});
            compare(e.tag, "running",  {7'd0, running},     {7'd0, e.running});
            compare(e.tag, "load_err", {7'd0, load_err},    {7'd0, e.load_err});
        end
    endtask

    // Drive one cycle of controls, predict the result, then check it after the edge.
    task automatic applyStimulus(input string tag, input logic t, input logic s,
                                 input logic p, input logic c, input logic l,
                                 input logic [7:0] lv);
        logic carry;
        logic lerr;
        @(negedge clock);
        tick       = t;
        start      = s;
        stop       = p;
        clear      = c;
        load       = l;
        load_value = lv;
        carry = 1'b0;
        lerr  = 1'b0;
        if (c) begin
            mdl_val   = 0;
            mdl_state = S_IDLE;
        end else if (l && (mdl_state != S_RUN)) begin
            if (preset_ok(lv)) begin
                mdl_val = from_bcd(lv);
                if (mdl_state == S_DONE) mdl_state = S_PAUSE;
            end else begin
                lerr = 1'b1;
            end
        end else if (p) begin
            if (mdl_state == S_RUN) mdl_state = S_PAUSE;
        end else if (s) begin
            if ((mdl_state == S_IDLE) || (mdl_state == S_PAUSE)) mdl_state = S_RUN;
        end else if (t && (mdl_state == S_RUN)) begin
`ifdef BCD_COUNTER_STOP_AT_MAX_EN
            if (mdl_val < MAX_INT) mdl_val = mdl_val + 1;
            if (mdl_val == MAX_INT) mdl_state = S_DONE;
`else
            if (mdl_val == MAX_INT) begin
                mdl_val = 0;
                carry   = 1'b1;
            end else begin
                mdl_val = mdl_val + 1;
            end
`endif
        end
        push_expect(tag, carry, lerr);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Reset state while reset_n is held low.
        #12;
        mdl_val   = 0;
        mdl_state = S_IDLE;
        push_expect("reset", 1'b0, 1'b0);
        checkOutput();
        @(negedge clock);
        reset_n = 1'b1;

        // start with a simultaneous tick does not count.
        applyStimulus("start_tick", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Ten back-to-back ticks, including the 09 -> 10 ripple.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("tick%0d", i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        compare("after10", "bcd", bcd, 8'h10);

        applyStimulus("tick11", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus("tick12", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // stop with a simultaneous tick holds the count in PAUSE.
        applyStimulus("stop_tick", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        compare("pause_hold", "bcd", bcd, 8'h12);
        applyStimulus("pause_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // clear outranks load.
        applyStimulus("clear_load", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33);

        // Wrap from the limit back to zero.
        applyStimulus("load58", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h58);
        applyStimulus("start58", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus("tick_to59", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        compare("at_limit", "bcd", bcd, 8'h59);
        applyStimulus("tick_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifndef BCD_COUNTER_STOP_AT_MAX_EN
        compare("wrap_carry", "carry", {7'd0, carry_out}, 8'h01);
`endif
        idle("after_wrap");

        // Rejected presets: bad nibble, then above the limit; then the limit itself.
        applyStimulus("clear1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus("load5A", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
        applyStimulus("load60", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h60);
        idle("err_gone");
        applyStimulus("load59", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h59);

        // Load while running is ignored without an error pulse.
        applyStimulus("clear2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus("start2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus("load_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h25);
        applyStimulus("tick_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a count.
        applyStimulus("clear3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus("load37", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h37);
        applyStimulus("start37", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus("tick38", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clock);
        tick = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        mdl_val   = 0;
        mdl_state = S_IDLE;
        push_expect("async_reset", 1'b0, 1'b0);
        checkOutput();
        @(negedge clock);
        reset_n = 1'b1;
        idle("post_reset");

`ifdef BCD_COUNTER_STOP_AT_MAX_EN
        // Stop at the limit, ignore start, leave DONE through a valid load.
        applyStimulus("load57", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h57);
        applyStimulus("start57", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("done_tick%0d", i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        compare("done_hold", "bcd", bcd, 8'h59);
        applyStimulus("done_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus("done_load10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        compare("done_exit", "bcd", bcd, 8'h10);
        applyStimulus("pause_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
